// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
package vend_pkg;

  localparam int DEF_CREDIT_W    = 7;
  localparam int DEF_CREDIT_MAX  = 99;
  localparam int DEF_PRICE_W     = 4;
  localparam int DEF_IDX_W       = 3;
  localparam int DEF_TIMEOUT_CYC = 1000;
  localparam int COIN_W          = 5;

  localparam logic [COIN_W-1:0] COIN_1  = 5'd1;
  localparam logic [COIN_W-1:0] COIN_5  = 5'd5;
  localparam logic [COIN_W-1:0] COIN_10 = 5'd10;
  localparam logic [COIN_W-1:0] COIN_20 = 5'd20;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    REFUND
  } vend_state_e;

  function automatic logic coin_legal(input logic [COIN_W-1:0] v);
    return (v == COIN_1) || (v == COIN_5) || (v == COIN_10) || (v == COIN_20);
  endfunction

endpackage

// File: rtl/vend_txn_ctrl_if.sv
// Front-panel, dispenser and hopper signals of the vending sequencer.
// master = sequencer side, slave = panel/dispenser/hopper side.
interface vend_txn_ctrl_if #(
  parameter int CREDIT_W = 7,
  parameter int PRICE_W  = 4,
  parameter int IDX_W    = 3
);
  logic                coin_valid;
  logic [4:0]          coin_val;
  logic                buy_req;
  logic [IDX_W-1:0]    sel_idx;
  logic [PRICE_W-1:0]  price;
  logic                refund_req;
  logic                disp_req;
  logic [IDX_W-1:0]    disp_idx;
  logic                disp_ack;
  logic                chg_req;
  logic [CREDIT_W-1:0] chg_amt;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                coin_reject;
  logic                err_nocredit;
  logic                err_timeout;

  modport master (
    input  coin_valid, coin_val, buy_req, sel_idx, price, refund_req,
           disp_ack, chg_ack,
    output disp_req, disp_idx, chg_req, chg_amt, credit, busy,
           coin_reject, err_nocredit, err_timeout
  );

  modport slave (
    output coin_valid, coin_val, buy_req, sel_idx, price, refund_req,
           disp_ack, chg_ack,
    input  disp_req, disp_idx, chg_req, chg_amt, credit, busy,
           coin_reject, err_nocredit, err_timeout
  );
endinterface

// File: rtl/vend_hs_timer.sv
// Handshake timeout counter shared by DISPENSE and REFUND; expired marks
// the TIMEOUT_CYC-th enabled cycle since the last clear.
module vend_hs_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CNT_W'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending credit transaction sequencer: arbitrates coin/buy/refund and runs
// dispenser/hopper handshakes with timeout. Option: VEND_AUTO_CHANGE_EN.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int CREDIT_W    = DEF_CREDIT_W,
  parameter int CREDIT_MAX  = DEF_CREDIT_MAX,
  parameter int PRICE_W     = DEF_PRICE_W,
  parameter int IDX_W       = DEF_IDX_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic             clk,
  input logic             rst,
  vend_txn_ctrl_if.master bus
);
  vend_state_e         state, state_nxt;
  logic [CREDIT_W-1:0] credit_q, credit_nxt;
  logic [CREDIT_W-1:0] amt_q, amt_nxt;
  logic [PRICE_W-1:0]  price_q, price_nxt;
  logic [IDX_W-1:0]    idx_q, idx_nxt;
  logic                coin_rej_q, coin_rej_nxt;
  logic                nocred_q, nocred_nxt;
  logic                tmo_q, tmo_nxt;
  logic                tmr_clr, tmr_expired;

  logic [CREDIT_W:0]   coin_sum;
  logic                coin_ok;
  logic                afford;
  logic [CREDIT_W-1:0] remain;

  // One extra bit on the sum so an over-limit coin cannot wrap into range.
  assign coin_sum = {1'b0, credit_q} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, bus.coin_val};
  assign coin_ok  = coin_legal(bus.coin_val) && (coin_sum <= (CREDIT_W + 1)'(CREDIT_MAX));
  assign afford   = (bus.price != '0) && (credit_q >= CREDIT_W'(bus.price));
  assign remain   = credit_q - CREDIT_W'(price_q);

  vend_hs_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (state != IDLE),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      credit_q   <= '0;
      amt_q      <= '0;
      price_q    <= '0;
      idx_q      <= '0;
      coin_rej_q <= 1'b0;
      nocred_q   <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      credit_q   <= credit_nxt;
      amt_q      <= amt_nxt;
      price_q    <= price_nxt;
      idx_q      <= idx_nxt;
      coin_rej_q <= coin_rej_nxt;
      nocred_q   <= nocred_nxt;
      tmo_q      <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit_q;
    amt_nxt      = amt_q;
    price_nxt    = price_q;
    idx_nxt      = idx_q;
    coin_rej_nxt = bus.coin_valid;
    nocred_nxt   = 1'b0;
    tmo_nxt      = 1'b0;
    tmr_clr      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.refund_req) begin
          if (credit_q != '0) begin
            state_nxt = REFUND;
            amt_nxt   = credit_q;
            tmr_clr   = 1'b1;
          end
        end else if (bus.buy_req) begin
          if (!afford) begin
            nocred_nxt = 1'b1;
          end else begin
            state_nxt = DISPENSE;
            price_nxt = bus.price;
            idx_nxt   = bus.sel_idx;
            tmr_clr   = 1'b1;
          end
        end else if (bus.coin_valid && coin_ok) begin
          credit_nxt   = coin_sum[CREDIT_W-1:0];
          coin_rej_nxt = 1'b0;
        end
      end

      DISPENSE: begin
        if (bus.disp_ack) begin
          credit_nxt = remain;
          state_nxt  = IDLE;
`ifdef VEND_AUTO_CHANGE_EN
          if (remain != '0) begin
            state_nxt = REFUND;
            amt_nxt   = remain;
            tmr_clr   = 1'b1;
          end
`endif
        end else if (tmr_expired) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end

      REFUND: begin
        if (bus.chg_ack) begin
          credit_nxt = '0;
          amt_nxt    = '0;
          state_nxt  = IDLE;
        end else if (tmr_expired) begin
          tmo_nxt   = 1'b1;
          amt_nxt   = '0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign bus.credit       = credit_q;
  assign bus.busy         = (state != IDLE);
  assign bus.disp_req     = (state == DISPENSE);
  assign bus.disp_idx     = idx_q;
  assign bus.chg_req      = (state == REFUND);
  assign bus.chg_amt      = amt_q;
  assign bus.coin_reject  = coin_rej_q;
  assign bus.err_nocredit = nocred_q;
  assign bus.err_timeout  = tmo_q;
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl; expectations follow VEND_AUTO_CHANGE_EN.
module tb_vend_txn_ctrl;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  vend_txn_ctrl_if #(.CREDIT_W(7), .PRICE_W(4), .IDX_W(3)) bus ();

  vend_txn_ctrl #(.TIMEOUT_CYC(TMO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input int v);
    bus.coin_valid = 1'b1;
    bus.coin_val   = 5'(v);
    tick();
    bus.coin_valid = 1'b0;
  endtask

  task automatic buy(input int p, input int idx);
    bus.buy_req = 1'b1;
    bus.price   = 4'(p);
    bus.sel_idx = 3'(idx);
    tick();
    bus.buy_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  // Expected outcome one cycle after a successful disp_ack, per build option.
  task automatic after_dispense(input string tag, input int rem);
`ifdef VEND_AUTO_CHANGE_EN
    if (rem != 0) begin
      check({tag, "_chg_req"}, bus.chg_req, 1);
      check({tag, "_chg_amt"}, bus.chg_amt, rem);
      check({tag, "_busy"}, bus.busy, 1);
      bus.chg_ack = 1'b1;
      tick();
      bus.chg_ack = 1'b0;
      check({tag, "_credit_after_chg"}, bus.credit, 0);
      return;
    end
`endif
    check({tag, "_credit"}, bus.credit, rem);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_chg_req"}, bus.chg_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.coin_valid = 1'b0;
    bus.coin_val   = '0;
    bus.buy_req    = 1'b0;
    bus.sel_idx    = '0;
    bus.price      = '0;
    bus.refund_req = 1'b0;
    bus.disp_ack   = 1'b0;
    bus.chg_ack    = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_credit", bus.credit, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_disp_req", bus.disp_req, 0);
    check("rst_chg_req", bus.chg_req, 0);
    check("rst_chg_amt", bus.chg_amt, 0);
    check("rst_disp_idx", bus.disp_idx, 0);
    check("rst_pulses", {bus.coin_reject, bus.err_nocredit, bus.err_timeout}, 0);
    rst = 1'b1;
    tick();

    // Coins 20,20,5 then buy price 7
    coin(20); check("c20_credit", bus.credit, 20);
    coin(20); check("c40_credit", bus.credit, 40);
    coin(5);  check("c45_credit", bus.credit, 45);
    check("c45_reject", bus.coin_reject, 0);
    buy(7, 3);
    check("buy_disp_req", bus.disp_req, 1);
    check("buy_disp_idx", bus.disp_idx, 3);
    check("buy_busy", bus.busy, 1);
    check("buy_credit", bus.credit, 45);
    tick();
    check("buy_hold_req", bus.disp_req, 1);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    check("ack_disp_req", bus.disp_req, 0);
    check("ack_credit", bus.credit, 38);
    after_dispense("ack", 38);

    // Ack in IDLE is ignored
    do_reset();
    coin(10);
    bus.chg_ack = 1'b1;
    bus.disp_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    bus.disp_ack = 1'b0;
    check("idle_ack_credit", bus.credit, 10);
    check("idle_ack_busy", bus.busy, 0);

    // Credit limit boundary and illegal coins
    do_reset();
    coin(20); coin(20); coin(20); coin(20); coin(10); coin(5);
    check("lim_credit95", bus.credit, 95);
    coin(5);
    check("lim_reject", bus.coin_reject, 1);
    check("lim_credit_kept", bus.credit, 95);
    tick();
    check("lim_reject_pulse", bus.coin_reject, 0);
    coin(1);
    check("lim_credit96", bus.credit, 96);
    check("lim_accept", bus.coin_reject, 0);
    coin(3);
    check("bad_coin_reject", bus.coin_reject, 1);
    check("bad_coin_credit", bus.credit, 96);
    coin(3); coin(0);
    check("zero_coin_reject", bus.coin_reject, 1);
    coin(1); coin(1); coin(1);
    check("max_credit99", bus.credit, 99);
    coin(1);
    check("over_max_reject", bus.coin_reject, 1);
    check("over_max_credit", bus.credit, 99);

    // Insufficient credit and disabled product
    do_reset();
    coin(1); coin(1); coin(1); coin(1);
    buy(5, 1);
    check("nocred_pulse", bus.err_nocredit, 1);
    check("nocred_disp_req", bus.disp_req, 0);
    check("nocred_busy", bus.busy, 0);
    tick();
    check("nocred_pulse_end", bus.err_nocredit, 0);
    buy(0, 1);
    check("price0_nocred", bus.err_nocredit, 1);
    check("price0_credit", bus.credit, 4);
    buy(4, 6);
    check("exact_disp_req", bus.disp_req, 1);
    check("exact_disp_idx", bus.disp_idx, 6);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    check("exact_credit", bus.credit, 0);
    check("exact_busy", bus.busy, 0);

    // Simultaneous refund/buy/coin: refund wins
    coin(20); coin(10);
    bus.refund_req = 1'b1;
    bus.buy_req    = 1'b1;
    bus.price      = 4'd5;
    bus.coin_valid = 1'b1;
    bus.coin_val   = 5'd5;
    tick();
    bus.refund_req = 1'b0;
    bus.buy_req    = 1'b0;
    bus.coin_valid = 1'b0;
    check("arb_chg_req", bus.chg_req, 1);
    check("arb_chg_amt", bus.chg_amt, 30);
    check("arb_coin_reject", bus.coin_reject, 1);
    check("arb_disp_req", bus.disp_req, 0);
    check("arb_credit", bus.credit, 30);
    coin(1);
    check("busy_coin_reject", bus.coin_reject, 1);
    check("busy_coin_credit", bus.credit, 30);
    buy(5, 2);
    check("busy_buy_ignored", bus.disp_req, 0);
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    check("refund_credit", bus.credit, 0);
    check("refund_chg_req", bus.chg_req, 0);
    check("refund_chg_amt", bus.chg_amt, 0);
    check("refund_busy", bus.busy, 0);

    // Refund with zero credit is ignored
    bus.refund_req = 1'b1;
    tick();
    bus.refund_req = 1'b0;
    check("refund0_busy", bus.busy, 0);

    // Dispense timeout, then late ack ignored
    coin(10);
    buy(6, 2);
    repeat (TMO - 1) tick();
    check("tmo_still_req", bus.disp_req, 1);
    check("tmo_not_yet", bus.err_timeout, 0);
    tick();
    check("tmo_pulse", bus.err_timeout, 1);
    check("tmo_disp_req", bus.disp_req, 0);
    check("tmo_credit", bus.credit, 10);
    check("tmo_busy", bus.busy, 0);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    check("late_ack_credit", bus.credit, 10);
    check("late_ack_pulse_end", bus.err_timeout, 0);

    // Ack on the expiry cycle counts as success
    buy(6, 2);
    repeat (TMO - 1) tick();
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    check("edge_ack_tmo", bus.err_timeout, 0);
    check("edge_ack_disp_req", bus.disp_req, 0);
    after_dispense("edge_ack", 4);

    // Asynchronous reset in the middle of REFUND
    do_reset();
    coin(20);
    bus.refund_req = 1'b1;
    tick();
    bus.refund_req = 1'b0;
    check("mid_chg_req", bus.chg_req, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_chg_req", bus.chg_req, 0);
    check("arst_chg_amt", bus.chg_amt, 0);
    check("arst_credit", bus.credit, 0);
    check("arst_busy", bus.busy, 0);
    tick();
    rst = 1'b1;

    // Remaining credit after purchase: auto change or retained
    coin(10); coin(1); coin(1);
    buy(5, 4);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    after_dispense("rem", 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
